link_data_arb_mux: RTL and testbench
====================================

Name: link_data_arb_mux

Overview:
N-channel link transmit multiplexer, the parametrised successor to the two-stream event/config link mux. Channel 0 is the non-blocking event stream, which has no ready. Channels 1..NUM_CH-1 are backpressured config streams served round-robin. One registered output with a channel tag feeds a link serializer that can stall. Event words lost to backpressure or starvation protection are counted.

Parameters:
NUM_CH, 4, total channels incl. event channel 0; legal range 2..16
DATA_W, 32, payload width
TY_W, $clog2(NUM_CH), tag width (derived localparam, 1 when NUM_CH=2)
STARVE_LIMIT, 8, max consecutive event wins while any config valid before one config word is forced; 0 disables
CNT_W, 16, drop counter width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
ev_valid  in  1  event word present (non-blocking, no ready)
ev_data  in  DATA_W  event payload
cfg_valid  in  NUM_CH-1  per config channel valid (bit i-1 = channel i)
cfg_data  in  (NUM_CH-1)*DATA_W  flattened payloads, channel i at [(i-1)*DATA_W +: DATA_W]
cfg_ready  out  NUM_CH-1  per config channel ready
out_valid  out  1  muxed word valid
out_ready  in  1  link accepts word
out_data  out  DATA_W  muxed payload
out_ty  out  TY_W  source channel (0 = event)
drop_cnt  out  CNT_W  saturating count of dropped event words
starve_active  out  1  high in cycles where config is forced over a valid event

Behaviour:
- Reset (async assert, sync deassert handled upstream): out_valid=0, out_data=0, out_ty=0, drop_cnt=0, rr_ptr=1, starve_cnt=0, starve_active=0.
- load = !out_valid || out_ready. The output register updates only when load=1. When load=1 and nothing is selected, out_valid goes to 0.
- Latency: accepted input appears at output on the next clk edge (1 cycle). Full throughput of one word per cycle while out_ready=1.
- Selection when load=1:
  - force = (STARVE_LIMIT!=0) && (starve_cnt==STARVE_LIMIT) && |cfg_valid.
  - If ev_valid && !force: event wins; out_data=ev_data, out_ty=0.
  - Else if |cfg_valid: the first valid channel searching from rr_ptr upward (wrapping NUM_CH-1 -> 1) wins; out_ty=i; cfg_ready[i]=1; rr_ptr <= i+1 (wraps to 1).
- cfg_ready is combinational from load, ev_valid, force, cfg_valid and rr_ptr. At most one bit is high. It is never high when load=0. A config word transfers when cfg_valid[i] && cfg_ready[i].
- Event drop: ev_valid && (!load || force) means the word is lost. drop_cnt increments by 1 and saturates at all-ones.
- starve_cnt:
  - Increments (capped at STARVE_LIMIT) on each event win with |cfg_valid=1.
  - Clears on any config grant, or when cfg_valid==0 at a load cycle.
  - Holds when load=0.
- starve_active = load && force && ev_valid (registered alongside output, i.e. reflects the previous cycle's decision). With STARVE_LIMIT=0 it stays 0.
- Output stable rule: while out_valid && !out_ready, out_data and out_ty hold.
- Config channels must hold valid/data until accepted. The block never drops config words.
- Reset mid-transfer: output word is discarded and counters and pointer return to reset values. No partial state survives.

Test Plan:
- Reset, then cfg_valid=3'b111 with data 0x11/0x22/0x33, out_ready=1, ev_valid=0 -> out_ty sequence 1,2,3,1,... with matching data, one word per cycle, cfg_ready one-hot.
- ev_valid=1 data 0xE0.. continuous, cfg_valid[0]=1, STARVE_LIMIT=8, out_ready=1 -> 8 event words (ty=0), then one ty=1 word with starve_active=1 next cycle, drop_cnt=1, then events resume.
- out_ready=0 for 5 cycles with out_valid=1 and ev_valid=1 each cycle -> out_data/out_ty frozen, drop_cnt=5, cfg_ready=0 throughout.
- STARVE_LIMIT=0, continuous events plus cfg_valid=3'b010 -> channel 2 never granted, drop_cnt stays 0, starve_active stays 0.
- CNT_W=4, drop 20 events via out_ready=0 -> drop_cnt saturates at 15.
- Assert rst_n=0 while out_valid=1 and rr_ptr=3 -> out_valid=0, drop_cnt=0 immediately. After release with cfg_valid=3'b111, the first grant is channel 1.

Source files
------------

// File: rtl/link_data_arb_mux.sv
// N-channel link transmit mux: non-blocking event channel 0 has priority over
// round-robin backpressured config channels, with starvation forcing and drop counting.
module link_data_arb_mux #(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 16,
  localparam int TY_W        = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ev_valid,
  input  logic [DATA_W-1:0]          ev_data,
  input  logic [NUM_CH-2:0]          cfg_valid,
  input  logic [(NUM_CH-1)*DATA_W-1:0] cfg_data,
  output logic [NUM_CH-2:0]          cfg_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [TY_W-1:0]            out_ty,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       starve_active
);

  localparam int NCFG = NUM_CH - 1;
  localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [TY_W-1:0]   rr_ptr;
  logic [SC_W-1:0]   starve_cnt;
  logic              load;
  logic              any_cfg;
  logic              force_cfg;
  logic              ev_win;
  logic              cfg_win;
  logic              drop;
  logic              found;
  logic [TY_W-1:0]   grant_ch;
  logic [TY_W-1:0]   next_ptr;
  logic [DATA_W-1:0] cfg_word;

  assign load      = !out_valid || out_ready;
  assign any_cfg   = |cfg_valid;
  assign force_cfg = (STARVE_LIMIT != 0) && (int'(starve_cnt) == STARVE_LIMIT) && any_cfg;
  assign ev_win    = load && ev_valid && !force_cfg;
  assign cfg_win   = load && !(ev_valid && !force_cfg) && any_cfg;
  assign drop      = ev_valid && (!load || force_cfg);

  // Round-robin search: first pass covers rr_ptr..NUM_CH-1, second pass wraps to the lowest channel.
  always_comb begin
    found    = 1'b0;
    grant_ch = '0;
    cfg_word = '0;
    for (int i = 1; i < NUM_CH; i++) begin
      if (!found && (i >= int'(rr_ptr)) && cfg_valid[i-1]) begin
        found    = 1'b1;
        grant_ch = TY_W'(i);
        cfg_word = cfg_data[(i-1)*DATA_W +: DATA_W];
      end
    end
    for (int i = 1; i < NUM_CH; i++) begin
      if (!found && cfg_valid[i-1]) begin
        found    = 1'b1;
        grant_ch = TY_W'(i);
        cfg_word = cfg_data[(i-1)*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    next_ptr = (int'(grant_ch) == NCFG) ? TY_W'(1) : grant_ch + 1'b1;
    for (int i = 1; i < NUM_CH; i++) begin
      cfg_ready[i-1] = cfg_win && (int'(grant_ch) == i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_ty        <= '0;
      starve_active <= 1'b0;
      rr_ptr        <= TY_W'(1);
      starve_cnt    <= '0;
    end else if (load) begin
      out_valid     <= ev_win || cfg_win;
      starve_active <= force_cfg && ev_valid;
      if (ev_win) begin
        out_data <= ev_data;
        out_ty   <= '0;
      end else if (cfg_win) begin
        out_data <= cfg_word;
        out_ty   <= grant_ch;
        rr_ptr   <= next_ptr;
      end
      // Consecutive event wins only matter while some config channel is waiting.
      if (ev_win && any_cfg) begin
        if (int'(starve_cnt) < STARVE_LIMIT) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else if (cfg_win || !any_cfg) begin
        starve_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_link_data_arb_mux.sv
// Directed bench for link_data_arb_mux: default, starvation-disabled and 4-bit-counter
// instances share one stimulus stream; each scenario checks the instance it targets.
module tb_link_data_arb_mux;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int TY_W   = $clog2(NUM_CH);

  logic                         clk;
  logic                         rst_n;
  logic                         ev_valid;
  logic [DATA_W-1:0]            ev_data;
  logic [NUM_CH-2:0]            cfg_valid;
  logic [(NUM_CH-1)*DATA_W-1:0] cfg_data;
  logic                         out_ready;

  logic [NUM_CH-2:0] a_cfg_ready, n_cfg_ready, c_cfg_ready;
  logic              a_out_valid, n_out_valid, c_out_valid;
  logic [DATA_W-1:0] a_out_data,  n_out_data,  c_out_data;
  logic [TY_W-1:0]   a_out_ty,    n_out_ty,    c_out_ty;
  logic [15:0]       a_drop_cnt,  n_drop_cnt;
  logic [3:0]        c_drop_cnt;
  logic              a_starve,    n_starve,    c_starve;

  int vec_count = 0;
  int err_count = 0;

  link_data_arb_mux u_dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_data(ev_data),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(a_cfg_ready),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_ty(a_out_ty), .drop_cnt(a_drop_cnt), .starve_active(a_starve)
  );

  link_data_arb_mux #(.STARVE_LIMIT(0)) u_nolim (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_data(ev_data),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(n_cfg_ready),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
    .out_ty(n_out_ty), .drop_cnt(n_drop_cnt), .starve_active(n_starve)
  );

  link_data_arb_mux #(.CNT_W(4)) u_cnt4 (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_data(ev_data),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(c_cfg_ready),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
    .out_ty(c_out_ty), .drop_cnt(c_drop_cnt), .starve_active(c_starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ev_v, input logic [31:0] ev_d,
                               input logic [2:0] cfg_v, input logic out_r);
    ev_valid  = ev_v;
    ev_data   = ev_d;
    cfg_valid = cfg_v;
    out_ready = out_r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetAll();
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    cfg_data = {32'h33, 32'h22, 32'h11};
    rst_n    = 1'b0;
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b0);
    tick();
    tick();
    checkOutput("rst_out_valid", 32'(a_out_valid), 32'd0);
    checkOutput("rst_out_data",  a_out_data,       32'd0);
    checkOutput("rst_out_ty",    32'(a_out_ty),    32'd0);
    checkOutput("rst_drop_cnt",  32'(a_drop_cnt),  32'd0);
    checkOutput("rst_starve",    32'(a_starve),    32'd0);

    // Round-robin across all three config channels, one word per cycle.
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 3'b111, 1'b1);
    checkOutput("rr_ready0", 32'(a_cfg_ready), 32'b001);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("rr_valid", 32'(a_out_valid), 32'd1);
      checkOutput("rr_ty",    32'(a_out_ty),    32'(k % 3 + 1));
      checkOutput("rr_data",  a_out_data,       32'(32'h11 * (k % 3 + 1)));
      checkOutput("rr_ready", 32'(a_cfg_ready), 32'(1 << ((k + 1) % 3)));
    end

    // Starvation forcing: 8 event wins, then channel 1 forced over a valid event.
    resetAll();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 32'(32'hE0 + k), 3'b001, 1'b1);
      checkOutput("st_ready", 32'(a_cfg_ready), (k == 8) ? 32'b001 : 32'b000);
      tick();
      checkOutput("st_ty",     32'(a_out_ty), (k == 8) ? 32'd1 : 32'd0);
      checkOutput("st_data",   a_out_data,    (k == 8) ? 32'h11 : 32'(32'hE0 + k));
      checkOutput("st_active", 32'(a_starve), (k == 8) ? 32'd1 : 32'd0);
    end
    checkOutput("st_drop", 32'(a_drop_cnt), 32'd1);

    // Stall: output frozen, events dropped, cfg_ready low; 4-bit counter saturates.
    resetAll();
    applyStimulus(1'b1, 32'hA5, 3'b001, 1'b1);
    tick();
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 32'(32'hB0 + k), 3'b001, 1'b0);
      checkOutput("stall_ready", 32'(a_cfg_ready), 32'd0);
      tick();
      if (k < 5) begin
        checkOutput("stall_data", a_out_data,    32'hA5);
        checkOutput("stall_ty",   32'(a_out_ty), 32'd0);
      end
      if (k == 4) checkOutput("stall_drop5", 32'(a_drop_cnt), 32'd5);
    end
    checkOutput("stall_drop20", 32'(a_drop_cnt), 32'd20);
    checkOutput("sat_drop",     32'(c_drop_cnt), 32'd15);
    checkOutput("sat_data",     c_out_data,      32'hA5);

    // STARVE_LIMIT=0 never forces; default instance forces channel 2 on the 9th cycle.
    resetAll();
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 32'(32'hC0 + k), 3'b010, 1'b1);
      checkOutput("nl_ready", 32'(n_cfg_ready), 32'd0);
      tick();
      checkOutput("nl_ty",   32'(n_out_ty), 32'd0);
      checkOutput("nl_data", n_out_data,    32'(32'hC0 + k));
      if (k == 8) checkOutput("lim_ty", 32'(a_out_ty), 32'd2);
    end
    checkOutput("nl_drop",   32'(n_drop_cnt), 32'd0);
    checkOutput("nl_starve", 32'(n_starve),   32'd0);

    // Reset while a word is held and rr_ptr points at channel 3.
    resetAll();
    applyStimulus(1'b1, 32'h5A, 3'b000, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h5B, 3'b000, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 3'b111, 1'b1);
    tick();
    tick();
    checkOutput("pre_ty",   32'(a_out_ty),   32'd2);
    checkOutput("pre_drop", 32'(a_drop_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_valid", 32'(a_out_valid), 32'd0);
    checkOutput("mid_drop",  32'(a_drop_cnt),  32'd0);
    checkOutput("mid_ty",    32'(a_out_ty),    32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("post_ready", 32'(a_cfg_ready), 32'b001);
    tick();
    checkOutput("post_ty",   32'(a_out_ty), 32'd1);
    checkOutput("post_data", a_out_data,    32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
